// File: rtl/gate_mix_pkg.sv
// rtl/gate_mix_pkg.sv - lane width, stage-1 payload struct and the two halves of the 4-bit gate network
package gate_mix_pkg;

  localparam int LANE_W = 4;

  typedef struct packed {
    logic nq;
    logic v;
    logic u;
    logic a2;
    logic t;
    logic m;
  } s1_lane_t;

  // First half of the network: everything up to the cut that S1 registers
  function automatic s1_lane_t lane_s1(input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
    logic p, q, n, e, m, t, u, v;
    s1_lane_t r;
    p = b[3] | a[0];
    q = p & a[1];
    n = ~(b[0] | a[1]);
    e = ~(a[3] ^ b[1]);
    m = ~(b[3] | e);
    t = b[1] & m;
    u = ~(e & (a[3] & b[0]));
    v = ~(n ^ (a[2] & b[2]));
    r.nq = n & q;
    r.v  = v;
    r.u  = u;
    r.a2 = a[2];
    r.t  = t;
    r.m  = m;
    return r;
  endfunction

  function automatic logic [LANE_W-1:0] lane_y(input s1_lane_t s);
    return {~(s.m | s.t), s.a2 ^ s.t, s.v ^ s.u, ~s.nq};
  endfunction

endpackage

// File: rtl/gate_mix_pipe_if.sv
// rtl/gate_mix_pipe_if.sv - valid/ready input and output channels of gate_mix_pipe
interface gate_mix_pipe_if #(parameter int LANES = 1);
  localparam int W = 4 * LANES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;

  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, y);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/gate_mix_lane.sv
// rtl/gate_mix_lane.sv - one 4-bit lane: S1 payload register and S2 result register
module gate_mix_lane
  import gate_mix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s1_load,
  input  logic              s2_load,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);

  s1_lane_t s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      y  <= '0;
    end else begin
      if (s1_load) s1 <= lane_s1(a, b);
      if (s2_load) y  <= lane_y(s1);
    end
  end

endmodule

// File: rtl/gate_mix_pipe.sv
// rtl/gate_mix_pipe.sv - LANES-wide 2-stage valid/ready gate-network pipe; GATE_MIX_SIG_EN adds an output signature
module gate_mix_pipe
  import gate_mix_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  gate_mix_pipe_if.slave            bus
`ifdef GATE_MIX_SIG_EN
  ,
  input  logic                      sig_clr,
  output logic [LANE_W*LANES-1:0]   sig
`endif
);

  localparam int W = LANE_W * LANES;

  logic         v1;
  logic         v2;
  logic         s1_en;
  logic         s2_en;
  logic [W-1:0] y_w;

  // A bubble in S2 lets S1 advance even while the sink stalls
  assign s2_en         = ~v2 | bus.out_ready;
  assign s1_en         = ~v1 | s2_en;
  assign bus.in_ready  = s1_en;
  assign bus.out_valid = v2;
  assign bus.y         = y_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (s2_en) v2 <= v1;
      if (s1_en) v1 <= bus.in_valid;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gate_mix_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_load (s1_en & bus.in_valid),
      .s2_load (s2_en & v1),
      .a       (bus.a[LANE_W*k +: LANE_W]),
      .b       (bus.b[LANE_W*k +: LANE_W]),
      .y       (y_w[LANE_W*k +: LANE_W])
    );
  end

`ifdef GATE_MIX_SIG_EN
  logic out_xfer;
  assign out_xfer = v2 & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (sig_clr) begin
      sig <= '0;
    end else if (out_xfer) begin
      sig <= {sig[W-2:0], sig[W-1]} ^ y_w;
    end
  end
`endif

endmodule

// File: tb/tb_gate_mix_pipe.sv
// tb/tb_gate_mix_pipe.sv - self-checking bench for gate_mix_pipe (LANES=2), signature checks under GATE_MIX_SIG_EN
module tb_gate_mix_pipe;

  localparam int LANES = 2;
  localparam int W     = 4 * LANES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_mix_pipe_if #(.LANES(LANES)) bif ();

`ifdef GATE_MIX_SIG_EN
  logic         sig_clr = 1'b0;
  logic [W-1:0] sig;
`endif

  gate_mix_pipe #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
`ifdef GATE_MIX_SIG_EN
    ,
    .sig_clr (sig_clr),
    .sig     (sig)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-lane function straight from the gate equations, no stage split
  function automatic logic [W-1:0] gold(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] r;
    logic [3:0] x, z;
    logic p, q, n, e, m, t, u, v;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      x = av[4*k +: 4];
      z = bv[4*k +: 4];
      p = z[3] | x[0];
      q = p & x[1];
      n = ~(z[0] | x[1]);
      e = ~(x[3] ^ z[1]);
      m = ~(z[3] | e);
      t = z[1] & m;
      u = ~(e & (x[3] & z[0]));
      v = ~(n ^ (x[2] & z[2]));
      r[4*k +: 4] = {~(m | t), x[2] ^ t, v ^ u, ~(n & q)};
    end
    return r;
  endfunction

  // Model: FIFO of expected results tagged with the edge that accepted them
  logic [W-1:0] q_y[$];
  int           q_e[$];
  logic [W-1:0] out_log[$];
  int           out_cyc[$];
  int           acc_cyc[$];
  logic [W-1:0] sig_m = '0;
  int           cyc = 0;
  bit           exp_ov;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_y.delete();
      q_e.delete();
      sig_m = '0;
      check("rst_out_valid", int'(bif.out_valid), 0);
      check("rst_y", int'(bif.y), 0);
      check("rst_in_ready", int'(bif.in_ready), 1);
`ifdef GATE_MIX_SIG_EN
      check("rst_sig", int'(sig), 0);
`endif
    end else begin
      exp_ov = (q_y.size() > 0) && (cyc >= q_e[0] + 1);
      check("out_valid", int'(bif.out_valid), int'(exp_ov));
      if (exp_ov && bif.out_valid) check("y", int'(bif.y), int'(q_y[0]));
      check("in_ready", int'(bif.in_ready), int'(!(q_y.size() >= 2 && !bif.out_ready)));
`ifdef GATE_MIX_SIG_EN
      check("sig", int'(sig), int'(sig_m));
`endif
      if (bif.out_valid && bif.out_ready) begin
        out_log.push_back(bif.y);
        out_cyc.push_back(cyc + 1);
        if (q_y.size() > 0) begin
`ifdef GATE_MIX_SIG_EN
          sig_m = {sig_m[W-2:0], sig_m[W-1]} ^ q_y[0];
`endif
          void'(q_y.pop_front());
          void'(q_e.pop_front());
        end
      end
`ifdef GATE_MIX_SIG_EN
      if (sig_clr) sig_m = '0;
`endif
      if (bif.in_valid && bif.in_ready) begin
        q_y.push_back(gold(bif.a, bif.b));
        q_e.push_back(cyc + 1);
        acc_cyc.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    bit acc;
    acc = 1'b0;
    bif.in_valid = 1'b1;
    bif.a = av;
    bif.b = bv;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bif.in_ready;
      tick();
    end
    if (!acc) check("send_timeout", 0, 1);
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 50 && out_log.size() < n; i++) tick();
    if (out_log.size() < n) check("wait_out_timeout", out_log.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    bif.in_valid  = 1'b0;
    bif.a         = '0;
    bif.b         = '0;
    bif.out_ready = 1'b1;
    repeat (2) tick();
    check("reset_out_valid_lit", int'(bif.out_valid), 0);
    check("reset_in_ready_lit", int'(bif.in_ready), 1);
    rst_n = 1'b1;
    tick();

    check("gold_00_00", int'(gold(8'h00, 8'h00)), 'hBB);
    check("gold_ff_ff", int'(gold(8'hFF, 8'hFF)), 'hDD);
    check("gold_88_00", int'(gold(8'h88, 8'h00)), 'h33);
    check("gold_f0_f0", int'(gold(8'hF0, 8'hF0)), 'hDB);

    base = out_log.size();
    send(8'h00, 8'h00);
    wait_out(base + 1);
    check("single_y", int'(out_log[base]), 'hBB);
    check("single_latency", out_cyc[base] - acc_cyc[acc_cyc.size()-1], 2);

    base = out_log.size();
    send(8'hFF, 8'hFF);
    send(8'h88, 8'h00);
    send(8'h88, 8'h22);
    wait_out(base + 3);
    check("b2b_y0", int'(out_log[base]), 'hDD);
    check("b2b_y1", int'(out_log[base+1]), 'h33);
    check("b2b_y2", int'(out_log[base+2]), 'hBB);
    check("b2b_gap0", out_cyc[base+1] - out_cyc[base], 1);
    check("b2b_gap1", out_cyc[base+2] - out_cyc[base+1], 1);

    base = out_log.size();
    send(8'hF0, 8'hF0);
    wait_out(base + 1);
    check("lanes_y", int'(out_log[base]), 'hDB);

    base = out_log.size();
    bif.out_ready = 1'b0;
    send(8'h0F, 8'h0F);
    send(8'h80, 8'h00);
    bif.in_valid = 1'b1;
    bif.a = 8'hFF;
    bif.b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(bif.in_ready), 0);
      check("stall_out_valid", int'(bif.out_valid), 1);
      check("stall_y", int'(bif.y), 'hBD);
      tick();
    end
    bif.out_ready = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    wait_out(base + 3);
    repeat (4) tick();
    check("bp_count", out_log.size(), base + 3);
    check("bp_y0", int'(out_log[base]), 'hBD);
    check("bp_y1", int'(out_log[base+1]), 'h3B);
    check("bp_y2", int'(out_log[base+2]), 'hDD);

    bif.out_ready = 1'b0;
    send(8'h00, 8'h00);
    send(8'hFF, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(bif.out_valid), 0);
    check("midrst_y", int'(bif.y), 0);
    tick();
    tick();
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    base = out_log.size();
    repeat (4) tick();
    check("midrst_no_emit", out_log.size(), base);
    send(8'hF0, 8'hF0);
    wait_out(base + 1);
    check("midrst_new_y", int'(out_log[base]), 'hDB);

`ifdef GATE_MIX_SIG_EN
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    check("sig_cleared", int'(sig), 0);
    base = out_log.size();
    send(8'h00, 8'h00);
    wait_out(base + 1);
    check("sig_first", int'(sig), 'hBB);
    send(8'h88, 8'h00);
    wait_out(base + 2);
    check("sig_second", int'(sig), 'h44);
    send(8'h00, 8'h00);
    tick();
    check("sig_clr_xfer_valid", int'(bif.out_valid), 1);
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    check("sig_clr_xfer_count", out_log.size(), base + 3);
    check("sig_clr_priority", int'(sig), 0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
